// File: rtl/adder_fp_multicycle.sv
// Multi-cycle IEEE-754 add/subtract with round-to-nearest-even and one operation in flight.
// Define ADDER_FP_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to signed zero.
module adder_fp_multicycle #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   localparam int W     = 1 + EXP_W + FRAC_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [1:0]   selector,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         zero,
   output logic         overflow,
   output logic         invalid
);

   localparam int M    = FRAC_W + 1;
   localparam int SH_W = $clog2(M + 4);
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [EXP_W-1:0] MAX_SH   = EXP_W'(FRAC_W + 3);
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
   } state_e;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [M-1:0]     mant;
   } opnd_t;

   function automatic opnd_t unpack(input logic [W-1:0] x, input logic flip);
      opnd_t             o;
      logic [EXP_W-1:0]  e;
      logic [FRAC_W-1:0] f;
      e      = x[W-2:FRAC_W];
      f      = x[FRAC_W-1:0];
      o.sign = x[W-1] ^ flip;
`ifdef ADDER_FP_SUBNORMAL_EN
      o.exp  = (e == '0) ? EXP_W'(1) : e;
      o.mant = {(e != '0), f};
`else
      o.exp  = e;
      o.mant = (e == '0) ? '0 : {1'b1, f};
`endif
      return o;
   endfunction

   function automatic logic [SH_W-1:0] lead_zeros(input logic [M+2:0] v);
      logic [SH_W-1:0] n;
      n = SH_W'(M + 3);
      for (int i = 0; i < M + 3; i++) begin
         if (v[i]) n = SH_W'(M + 2 - i);
      end
      return n;
   endfunction

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [1:0]     sel_q, sel_d;
   opnd_t          opa_q, opa_d, opb_q, opb_d;
   logic           spec_q, spec_d;
   logic [W-1:0]   word_q, word_d;
   logic           inv_q, inv_d, ovf_q, ovf_d;
   logic           sign_q, sign_d, sub_q, sub_d, zres_q, zres_d;
   logic [EXP_W:0] exp_q, exp_d;
   logic [M+3:0]   mant_q, mant_d;
   logic [M+2:0]   small_q, small_d;
   logic [W-1:0]   result_q, result_d;
   logic           zero_q, zero_d, overflow_q, overflow_d, invalid_q, invalid_d;
   logic           out_valid_q, out_valid_d;

   // Unpack: field split and classification of the latched operands.
   opnd_t ua, ub;
   logic  a_nan, b_nan, a_inf, b_inf;

   assign ua    = unpack(a_q, 1'b0);
   assign ub    = unpack(b_q, sel_q[0]);
   assign a_nan = (a_q[W-2:FRAC_W] == EXP_ONES) && (a_q[FRAC_W-1:0] != '0);
   assign b_nan = (b_q[W-2:FRAC_W] == EXP_ONES) && (b_q[FRAC_W-1:0] != '0);
   assign a_inf = (a_q[W-2:FRAC_W] == EXP_ONES) && (a_q[FRAC_W-1:0] == '0);
   assign b_inf = (b_q[W-2:FRAC_W] == EXP_ONES) && (b_q[FRAC_W-1:0] == '0);

   // Align: larger magnitude first, smaller shifted right with guard/round/sticky.
   logic             a_big;
   opnd_t            big, sml;
   logic [EXP_W-1:0] diff;
   logic [SH_W-1:0]  sh_amt;
   logic [M+2:0]     ext_sml, sh_mask, aligned;
   logic             sticky;

   assign a_big   = {opa_q.exp, opa_q.mant} >= {opb_q.exp, opb_q.mant};
   assign big     = a_big ? opa_q : opb_q;
   assign sml     = a_big ? opb_q : opa_q;
   assign diff    = big.exp - sml.exp;
   assign sh_amt  = (diff > MAX_SH) ? MAX_SH[SH_W-1:0] : diff[SH_W-1:0];
   assign ext_sml = {sml.mant, 3'b000};
   assign sh_mask = ~({(M+3){1'b1}} << sh_amt);
   assign sticky  = |(ext_sml & sh_mask);
   assign aligned = (ext_sml >> sh_amt) | {{(M+2){1'b0}}, sticky};

   // Normalise: leading-zero count over everything below the carry bit.
   logic [SH_W-1:0] lzc;
   logic [EXP_W:0]  lzc_x;

   assign lzc   = lead_zeros(mant_q[M+2:0]);
   assign lzc_x = (EXP_W+1)'(lzc);

   // Round: mant_q = {carry, hidden, fraction, G, R, S}.
   logic           rnd_up;
   logic [M:0]     rnd;
   logic [M-1:0]   sig_r;
   logic [EXP_W:0] exp_r;

   assign rnd_up = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
   assign rnd    = {1'b0, mant_q[M+2:3]} + (M+1)'(rnd_up);
   assign sig_r  = rnd[M] ? rnd[M:1] : rnd[M-1:0];
   assign exp_r  = rnd[M] ? exp_q + (EXP_W+1)'(1) : exp_q;

   always_comb begin
      // NOTE: every _d takes its _q value first, so no branch can leave one unassigned (no latches).
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sel_d       = sel_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      spec_d      = spec_q;
      word_d      = word_q;
      inv_d       = inv_q;
      ovf_d       = ovf_q;
      sign_d      = sign_q;
      sub_d       = sub_q;
      zres_d      = zres_q;
      exp_d       = exp_q;
      mant_d      = mant_q;
      small_d     = small_q;
      result_d    = result_q;
      zero_d      = zero_q;
      overflow_d  = overflow_q;
      invalid_d   = invalid_q;
      out_valid_d = out_valid_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               sel_d   = selector;
               state_d = S_UNPACK;
            end
         end
         S_UNPACK: begin
            opa_d   = ua;
            opb_d   = ub;
            inv_d   = 1'b0;
            ovf_d   = 1'b0;
            spec_d  = 1'b1;
            state_d = S_ALIGN;
            if (a_nan || b_nan || (a_inf && b_inf && (ua.sign != ub.sign))) begin
               word_d = QNAN;
               inv_d  = 1'b1;
            end else if (a_inf) begin
               word_d = {ua.sign, EXP_ONES, {FRAC_W{1'b0}}};
            end else if (b_inf) begin
               word_d = {ub.sign, EXP_ONES, {FRAC_W{1'b0}}};
            end else begin
               spec_d = 1'b0;
            end
         end
         S_ALIGN: begin
            if (spec_q) begin
               state_d = S_DONE;
            end else begin
               sign_d  = big.sign;
               sub_d   = big.sign ^ sml.sign;
               exp_d   = {1'b0, big.exp};
               mant_d  = {1'b0, big.mant, 3'b000};
               small_d = aligned;
               zres_d  = 1'b0;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            mant_d  = sub_q ? mant_q - {1'b0, small_q} : mant_q + {1'b0, small_q};
            state_d = S_NORM;
         end
         S_NORM: begin
            state_d = S_ROUND;
            if (mant_q[M+3]) begin
               mant_d = {1'b0, mant_q[M+3:2], mant_q[1] | mant_q[0]};
               exp_d  = exp_q + (EXP_W+1)'(1);
            end else if (mant_q == '0) begin
               // Exact cancellation rounds to +0; only -0 + -0 keeps the minus sign.
               zres_d = 1'b1;
               sign_d = sub_q ? 1'b0 : sign_q;
            end else if (lzc_x >= exp_q) begin
`ifdef ADDER_FP_SUBNORMAL_EN
               mant_d = mant_q << (exp_q - (EXP_W+1)'(1));
               exp_d  = (EXP_W+1)'(1);
`else
               zres_d = 1'b1;
`endif
            end else begin
               mant_d = mant_q << lzc;
               exp_d  = exp_q - lzc_x;
            end
         end
         S_ROUND: begin
            state_d = S_DONE;
            if (zres_q) begin
               word_d = {sign_q, {(W-1){1'b0}}};
            end else if (exp_r >= {1'b0, EXP_ONES}) begin
               word_d = {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
               ovf_d  = 1'b1;
            end else begin
               // A clear hidden bit at exponent 1 is a subnormal, encoded with exponent field 0.
               word_d = {sign_q, (sig_r[M-1] ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), sig_r[M-2:0]};
            end
         end
         S_DONE: begin
            // First DONE cycle loads the output register; afterwards it holds until accepted.
            if (!out_valid_q) begin
               result_d    = {word_q[W-1] ^ (sel_q[1] & ~inv_q), word_q[W-2:0]};
               zero_d      = (word_q[W-2:0] == '0);
               overflow_d  = ovf_q;
               invalid_d   = inv_q;
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         spec_q      <= 1'b0;
         word_q      <= '0;
         inv_q       <= 1'b0;
         ovf_q       <= 1'b0;
         sign_q      <= 1'b0;
         sub_q       <= 1'b0;
         zres_q      <= 1'b0;
         exp_q       <= '0;
         mant_q      <= '0;
         small_q     <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         overflow_q  <= 1'b0;
         invalid_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking only, so every register samples the same pre-edge values.
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sel_q       <= sel_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         spec_q      <= spec_d;
         word_q      <= word_d;
         inv_q       <= inv_d;
         ovf_q       <= ovf_d;
         sign_q      <= sign_d;
         sub_q       <= sub_d;
         zres_q      <= zres_d;
         exp_q       <= exp_d;
         mant_q      <= mant_d;
         small_q     <= small_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         overflow_q  <= overflow_d;
         invalid_q   <= invalid_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign overflow  = overflow_q;
   assign invalid   = invalid_q;

endmodule
